inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Inverse of the immediate/field decode path: packs operand fields and a 32-bit immediate into an RV32I instruction word for a given InstructionType.
- Input side is a valid/ready port with a combinational encode stage. Output side is a FIFO_DEPTH-entry buffer with a valid/ready port.
- Used by the self-test instruction generator and by the assembler-side bench.
- Flags immediates that the selected format cannot represent and keeps saturating counters of emitted and flagged words.

Parameters:
FIFO_DEPTH, 2, output buffer entries (power of 2, >=2)
COUNT_W, 16, width of enc_count and err_count

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous flush: empty the buffer; counters keep their values
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_type  in  InstructionType  INST_TYPE_R/I/S/B/U/J (typedefs)
in_opcode  in  7  placed at inst[6:0] for all valid types
in_rd  in  5  rd field
in_funct3  in  3  funct3 field
in_rs1  in  5  rs1 field
in_rs2  in  5  rs2 field
in_funct7  in  7  funct7 field (R only)
in_imm  in  32  immediate value, two's complement
out_valid  out  1  buffer head valid
out_ready  in  1  consumer pop
out_inst  out  32  encoded word at buffer head
out_err  out  1  range error of the head entry
enc_count  out  COUNT_W  words popped, saturating
err_count  out  COUNT_W  accepted erroneous words, saturating

Behaviour:
- Reset (rst_n low, asynchronous):
  - Buffer empty, read and write pointers 0.
  - out_valid=0, out_inst=0, out_err=0, enc_count=0, err_count=0.
  - Reset mid-operation discards all entries.
- in_ready = !full && !flush. It is combinational and reads 1 during and after reset.
- Accept at edge N writes the encoded word into the buffer. out_valid is high after edge N when the buffer was empty, so latency is 1 cycle.
- No bypass when full:
  - Push while full is impossible because in_ready is low.
  - Push and pop in the same cycle with the buffer neither full nor empty keeps the occupancy unchanged.
- Pop on out_valid && out_ready. out_inst and out_err come from registered buffer storage and stay stable while out_valid && !out_ready.
- flush: at the next edge the buffer is empty and out_valid=0. Any pending pop or push in that cycle is ignored and not counted.
- Encoding (standard RV32I):
  - R: funct7|rs2|rs1|funct3|rd|opcode. imm is ignored and never errors.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
  - Any other in_type value: word = 0 and err = 1.
- Range rules (signed), err=1 if violated:
  - I and S: -2048..2047.
  - B: -4096..4094 and imm[0]=0.
  - J: -1048576..1048574 and imm[0]=0.
  - U: imm[11:0]=0.
- On a range error the word is still emitted, with the immediate truncated to the format's bits, and err=1 is stored with the entry.
- err_count increments on accept of an erroneous entry. enc_count increments on each pop. Both saturate at 2^COUNT_W-1 and never wrap.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an occupancy counter of width clog2(FIFO_DEPTH)+1.

Test Plan:
1. I-type addi: opcode 0010011, rd=1, funct3=0, rs1=0, imm=5, out_ready=1 -> out_valid 1 cycle after accept, out_inst 0x00500093, out_err 0, enc_count 1.
2. B-type beq: opcode 1100011, rs1=1, rs2=2, funct3=0, imm=0xFFFFFFF8 -> out_inst 0xFE208CE3, err 0. Then U-type lui: opcode 0110111, rd=5, imm=0x12345000 -> out_inst 0x123452B7.
3. J-type jal: opcode 1101111, rd=1, imm=0x800 -> out_inst 0x001000EF. The same with imm=0x801 -> err 1, err_count 1.
4. I-type with imm=2048, otherwise as scenario 1 -> out_inst 0x80000093, out_err 1, err_count increments. Invalid in_type -> out_inst 0, out_err 1.
5. Backpressure with FIFO_DEPTH=2:
   - out_ready=0, offer 3 back-to-back words.
   - in_ready low after 2 accepts; the third word is held.
   - Then raise out_ready: words emerge in order, the third is accepted on the first pop, enc_count=3 after drain.
6. Load 2 entries, then assert flush together with in_valid and out_ready -> buffer empty, out_valid 0, enc_count unchanged. Then drop rst_n mid-stream -> all outputs 0 immediately (asynchronous), in_ready 1.

Source files
------------

// File: rtl/inst_encoder.sv
// RV32I instruction word encoder: packs operand fields and an immediate into a
// 32-bit word, flags unrepresentable immediates, and buffers results in a small FIFO.

package inst_encoder_pkg;
    typedef enum logic [2:0] {
        INST_TYPE_R = 3'd0,
        INST_TYPE_I = 3'd1,
        INST_TYPE_S = 3'd2,
        INST_TYPE_B = 3'd3,
        INST_TYPE_U = 3'd4,
        INST_TYPE_J = 3'd5
    } inst_type_e;

    typedef struct packed {
        logic        err;
        logic [31:0] inst;
    } enc_entry_t;
endpackage

module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned COUNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  inst_type_e         in_type,
    input  logic [6:0]         in_opcode,
    input  logic [4:0]         in_rd,
    input  logic [2:0]         in_funct3,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [6:0]         in_funct7,
    input  logic [31:0]        in_imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_inst,
    output logic               out_err,
    output logic [COUNT_W-1:0] enc_count,
    output logic [COUNT_W-1:0] err_count
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    enc_entry_t    enc_c;
    enc_entry_t    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic          full;
    logic          push;
    logic          pop;
    logic          fit12;
    logic          fit13;
    logic          fit21;

    // Signed-range checks: upper bits must be a pure sign extension
    assign fit12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign fit13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign fit21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    always_comb begin
        enc_c = '0;
        case (in_type)
            INST_TYPE_R: begin
                enc_c.inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            end
            INST_TYPE_I: begin
                enc_c.inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                enc_c.err  = ~fit12;
            end
            INST_TYPE_S: begin
                enc_c.inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                enc_c.err  = ~fit12;
            end
            INST_TYPE_B: begin
                enc_c.inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], in_opcode};
                enc_c.err  = ~fit13 | in_imm[0];
            end
            INST_TYPE_U: begin
                enc_c.inst = {in_imm[31:12], in_rd, in_opcode};
                enc_c.err  = |in_imm[11:0];
            end
            INST_TYPE_J: begin
                enc_c.inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                enc_c.err  = ~fit21 | in_imm[0];
            end
            default: begin
                enc_c.inst = '0;
                enc_c.err  = 1'b1;
            end
        endcase
    end

    assign full      = (count == CW'(FIFO_DEPTH));
    assign in_ready  = ~full & ~flush;
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready & ~flush;
    assign out_inst  = mem[rptr].inst;
    assign out_err   = mem[rptr].err;

    // Buffer storage, cleared on reset so the head reads zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wptr] <= enc_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Saturating statistics; push already excludes flush cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count <= '0;
            err_count <= '0;
        end else begin
            if (pop && (enc_count != '1)) begin
                enc_count <= enc_count + COUNT_W'(1);
            end
            if (push && enc_c.err && (err_count != '1)) begin
                err_count <= err_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed scenarios plus random traffic checked
// against a queue-based reference model.

module tb_inst_encoder;
    import inst_encoder_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = 4;
    localparam int          SAT   = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    inst_type_e    in_type = INST_TYPE_R;
    logic [6:0]    in_opcode = '0;
    logic [4:0]    in_rd = '0;
    logic [2:0]    in_funct3 = '0;
    logic [4:0]    in_rs1 = '0;
    logic [4:0]    in_rs2 = '0;
    logic [6:0]    in_funct7 = '0;
    logic [31:0]   in_imm = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_inst;
    logic          out_err;
    logic [CW-1:0] enc_count;
    logic [CW-1:0] err_count;

    inst_encoder #(.FIFO_DEPTH(DEPTH), .COUNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_err(out_err), .enc_count(enc_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   m_enc = 0;
    int   m_err = 0;
    int   errors = 0;
    int   checks = 0;
    bit   last_acc;

    // Reference encoder: field placement and signed range rules from the ISA
    function automatic exp_t model(logic [2:0] t, logic [6:0] op, logic [4:0] rd,
                                   logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2,
                                   logic [6:0] f7, logic [31:0] imm);
        exp_t r;
        int   s;
        s = $signed(imm);
        r.inst = 32'h0;
        r.err  = 1'b0;
        case (t)
            3'd0: r.inst = {f7, rs2, rs1, f3, rd, op};
            3'd1: begin
                r.inst = {imm[11:0], rs1, f3, rd, op};
                r.err  = (s < -2048) || (s > 2047);
            end
            3'd2: begin
                r.inst = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
                r.err  = (s < -2048) || (s > 2047);
            end
            3'd3: begin
                r.inst = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
                r.err  = (s < -4096) || (s > 4094) || (s % 2 != 0);
            end
            3'd4: begin
                r.inst = {imm[31:12], rd, op};
                r.err  = (imm % 4096) != 0;
            end
            3'd5: begin
                r.inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                r.err  = (s < -1048576) || (s > 1048574) || (s % 2 != 0);
            end
            default: begin
                r.inst = 32'h0;
                r.err  = 1'b1;
            end
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_inst", out_inst, q[0].inst);
            chk("out_err", 32'(out_err), 32'(q[0].err));
        end
        chk("enc_count", 32'(enc_count), 32'(m_enc));
        chk("err_count", 32'(err_count), 32'(m_err));
    endtask

    // One clock: inputs already driven at the falling edge
    task automatic step();
        bit   acc;
        bit   pop;
        exp_t e;
        #1;
        acc = in_valid && !flush && (q.size() < int'(DEPTH));
        pop = out_ready && !flush && (q.size() != 0);
        chk("in_ready", 32'(in_ready), 32'(!flush && (q.size() < int'(DEPTH))));
        e = model(in_type, in_opcode, in_rd, in_funct3, in_rs1, in_rs2, in_funct7, in_imm);
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (pop) begin
                void'(q.pop_front());
                if (m_enc < SAT) m_enc++;
            end
            if (acc) begin
                q.push_back(e);
                if (e.err && m_err < SAT) m_err++;
            end
        end
        last_acc = acc;
        @(negedge clk);
        check_out();
    endtask

    task automatic req(input inst_type_e t, input logic [6:0] op, input logic [4:0] rd,
                       input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
        in_valid  = 1'b1;
        in_type   = t;
        in_opcode = op;
        in_rd     = rd;
        in_funct3 = f3;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct7 = 7'h00;
        in_imm    = imm;
    endtask

    task automatic randomize_inputs();
        int sel;
        in_valid  = ($urandom_range(0, 3) != 0);
        in_type   = inst_type_e'(3'($urandom_range(0, 7)));
        in_opcode = 7'($urandom);
        in_rd     = 5'($urandom);
        in_funct3 = 3'($urandom);
        in_rs1    = 5'($urandom);
        in_rs2    = 5'($urandom);
        in_funct7 = 7'($urandom);
        sel = int'($urandom_range(0, 3));
        case (sel)
            0: in_imm = 32'($urandom_range(0, 10000)) - 32'd5000;
            1: in_imm = $urandom;
            2: in_imm = (32'($urandom_range(0, 2200000)) - 32'd1100000) & 32'hFFFF_FFFE;
            default: in_imm = $urandom & 32'hFFFF_F000;
        endcase
        out_ready = ($urandom_range(0, 2) != 0);
        flush     = ($urandom_range(0, 31) == 0);
    endtask

    initial begin
        int base;
        bit got;

        // Reset state
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_enc_count", 32'(enc_count), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // addi x1, x0, 5
        out_ready = 1'b1;
        req(INST_TYPE_I, 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 32'd5);
        step();
        in_valid = 1'b0;
        chk("t1_inst", out_inst, 32'h0050_0093);
        chk("t1_err", 32'(out_err), 32'd0);
        step();
        chk("t1_enc", 32'(enc_count), 32'd1);

        // beq x1, x2, -8 then lui x5, 0x12345
        req(INST_TYPE_B, 7'b1100011, 5'd0, 3'd0, 5'd1, 5'd2, 32'hFFFF_FFF8);
        step();
        in_valid = 1'b0;
        chk("t2_beq", out_inst, 32'hFE20_8CE3);
        chk("t2_beq_err", 32'(out_err), 32'd0);
        req(INST_TYPE_U, 7'b0110111, 5'd5, 3'd0, 5'd0, 5'd0, 32'h1234_5000);
        step();
        in_valid = 1'b0;
        chk("t2_lui", out_inst, 32'h1234_52B7);
        step();

        // jal x1, 0x800 and a misaligned variant
        req(INST_TYPE_J, 7'b1101111, 5'd1, 3'd0, 5'd0, 5'd0, 32'h0000_0800);
        step();
        in_valid = 1'b0;
        chk("t3_jal", out_inst, 32'h0010_00EF);
        chk("t3_jal_err", 32'(out_err), 32'd0);
        req(INST_TYPE_J, 7'b1101111, 5'd1, 3'd0, 5'd0, 5'd0, 32'h0000_0801);
        step();
        in_valid = 1'b0;
        chk("t3_odd_err", 32'(out_err), 32'd1);
        chk("t3_err_count", 32'(err_count), 32'd1);
        step();

        // I immediate out of range, then an undefined type
        req(INST_TYPE_I, 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 32'd2048);
        step();
        in_valid = 1'b0;
        chk("t4_inst", out_inst, 32'h8000_0093);
        chk("t4_err", 32'(out_err), 32'd1);
        chk("t4_err_count", 32'(err_count), 32'd2);
        req(inst_type_e'(3'd7), 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 32'd0);
        step();
        in_valid = 1'b0;
        chk("t4_bad_inst", out_inst, 32'd0);
        chk("t4_bad_err", 32'(out_err), 32'd1);
        step();

        // Backpressure: three offers into a two-entry buffer
        base = m_enc;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req(INST_TYPE_I, 7'b0010011, 5'(k + 1), 3'd0, 5'd0, 5'd0, 32'(k + 10));
            step();
        end
        chk("t5_held", 32'(last_acc), 32'd0);
        chk("t5_ready_low", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 4 && !got; k++) begin
            step();
            got = last_acc;
        end
        chk("t5_third_accepted", 32'(got), 32'd1);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("t5_enc_count", 32'(enc_count), 32'(base + 3));

        // Flush overrides simultaneous push and pop
        out_ready = 1'b0;
        req(INST_TYPE_R, 7'b0110011, 5'd3, 3'd0, 5'd1, 5'd2, 32'd0);
        step();
        step();
        base = m_enc;
        flush = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t6_flush_valid", 32'(out_valid), 32'd0);
        chk("t6_flush_enc", 32'(enc_count), 32'(base));
        step();

        // Random traffic with an asynchronous reset in the middle
        for (int n = 0; n < 600; n++) begin
            randomize_inputs();
            step();
            if (n == 300) begin
                flush = 1'b0;
                #2;
                rst_n = 1'b0;
                #1;
                chk("rst_mid_valid", 32'(out_valid), 32'd0);
                chk("rst_mid_inst", out_inst, 32'd0);
                chk("rst_mid_err", 32'(out_err), 32'd0);
                chk("rst_mid_enc", 32'(enc_count), 32'd0);
                chk("rst_mid_errc", 32'(err_count), 32'd0);
                chk("rst_mid_ready", 32'(in_ready), 32'd1);
                q.delete();
                m_enc = 0;
                m_err = 0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
